// File: rtl/seguimiento_pkg.sv
// Shared codes for the two-axis solar tracker controller:
// mode codes, motor command codes and FSM state encoding.
package seguimiento_pkg;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_CW   = 2'b01;
  localparam logic [1:0] CMD_CCW  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_THETA,
    S_THETA_SETTLE,
    S_PHI,
    S_PHI_SETTLE,
    S_DONE,
    S_FAULT
  } state_e;

endpackage

// File: rtl/control_seguimiento_axis_cmp.sv
// Per-axis comparator: balance flag and motor command from either a
// sensor pair (auto) or a target/actual angle pair (manual, modular).
// Ports: manual select, a/b readings, target/actual, balanced, cmd.
module axis_cmp
  import seguimiento_pkg::*;
#(
  parameter int W         = 16,
  parameter int DEADBAND  = 5,
  parameter int ANGLE_MAX = 360
) (
  input  logic         manual,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] target,
  input  logic [W-1:0] actual,
  output logic         balanced,
  output logic [1:0]   cmd
);

  localparam int AW = W + 2;
  localparam logic [W:0]    DB_A = (W+1)'(DEADBAND);
  localparam logic [AW-1:0] DB_M = AW'(DEADBAND);
  localparam logic [AW-1:0] AMAX = AW'(ANGLE_MAX);

  logic [W:0]    diff;
  logic [W:0]    mag;
  logic          auto_bal;
  logic          auto_cw;
  logic [AW-1:0] t_w;
  logic [AW-1:0] a_w;
  logic [AW-1:0] err;
  logic [AW-1:0] err_inv;
  logic [AW-1:0] err_min;
  logic          man_bal;
  logic          man_cw;
  logic          cw;

  always_comb begin
    // one extra bit keeps a<b from wrapping into a small value
    diff     = {1'b0, a} - {1'b0, b};
    mag      = diff[W] ? ((W+1)'(0) - diff) : diff;
    auto_bal = (mag <= DB_A);
    auto_cw  = ~diff[W];

    t_w     = {2'b00, target};
    a_w     = {2'b00, actual};
    err     = (t_w >= a_w) ? (t_w - a_w) : (t_w + AMAX - a_w);
    err_inv = AMAX - err;
    err_min = (err < err_inv) ? err : err_inv;
    man_bal = (err_min <= DB_M);
    man_cw  = (err <= (AMAX >> 1));

    balanced = manual ? man_bal : auto_bal;
    cw       = manual ? man_cw : auto_cw;
    cmd      = balanced ? CMD_STOP : (cw ? CMD_CW : CMD_CCW);
  end

endmodule

// File: rtl/control_seguimiento.sv
// Two-axis tracker sequencer: moves theta then phi, settles each,
// with hold, timeout and invalid-angle fault. All outputs registered.
// Ports: clk, rst, mode, sensor readings, angles, motor cmds, flags.
module control_seguimiento
  import seguimiento_pkg::*;
#(
  parameter int W         = 16,
  parameter int DEADBAND  = 5,
  parameter int ANGLE_MAX = 360,
  parameter int SETTLE    = 4,
  parameter int TIMEOUT   = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic [W-1:0] r_v1,
  input  logic [W-1:0] r_v2,
  input  logic [W-1:0] r_h1,
  input  logic [W-1:0] r_h2,
  input  logic [W-1:0] theta_target,
  input  logic [W-1:0] phi_target,
  input  logic [W-1:0] theta_actual,
  input  logic [W-1:0] phi_actual,
  output logic [1:0]   s_out_theta,
  output logic [1:0]   s_out_phi,
  output logic         busy,
  output logic         on_target,
  output logic         fault
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int DW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_N  = SW'(SETTLE);
  localparam logic [DW-1:0] TIMEOUT_N = DW'(TIMEOUT);
  localparam logic [W:0]    AMAX      = (W+1)'(ANGLE_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d, settle_nx;
  logic [DW-1:0] drive_q, drive_d;
  logic [1:0]    last_mode_q, last_mode_d;
  logic [1:0]    th_q, th_d;
  logic [1:0]    ph_q, ph_d;
  logic          busy_q, busy_d;
  logic          on_target_q, on_target_d;
  logic          fault_q, fault_d;

  logic       manual;
  logic       bad_angle;
  logic       th_bal, ph_bal;
  logic [1:0] th_cmd, ph_cmd;

  assign manual = (mode == MODE_MANUAL);

  axis_cmp #(.W(W), .DEADBAND(DEADBAND), .ANGLE_MAX(ANGLE_MAX)) u_theta (
    .manual   (manual),
    .a        (r_v1),
    .b        (r_v2),
    .target   (theta_target),
    .actual   (theta_actual),
    .balanced (th_bal),
    .cmd      (th_cmd)
  );

  axis_cmp #(.W(W), .DEADBAND(DEADBAND), .ANGLE_MAX(ANGLE_MAX)) u_phi (
    .manual   (manual),
    .a        (r_h1),
    .b        (r_h2),
    .target   (phi_target),
    .actual   (phi_actual),
    .balanced (ph_bal),
    .cmd      (ph_cmd)
  );

  always_comb begin
    bad_angle = ({1'b0, theta_target} >= AMAX) ||
                ({1'b0, phi_target}   >= AMAX) ||
                ({1'b0, theta_actual} >= AMAX) ||
                ({1'b0, phi_actual}   >= AMAX);
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    drive_d     = drive_q;
    last_mode_d = last_mode_q;
    th_d        = CMD_STOP;
    ph_d        = CMD_STOP;
    settle_nx   = settle_q + SW'(1);

    // hold never overwrites the mode it will resume into
    if (mode != MODE_HOLD) last_mode_d = mode;

    if (mode == MODE_IDLE) begin
      state_d  = S_IDLE;
      settle_d = '0;
      drive_d  = '0;
    end else if (state_q == S_FAULT) begin
      state_d = S_FAULT;
    end else if (mode == MODE_HOLD) begin
      state_d = state_q;
    end else if (manual && bad_angle) begin
      state_d = S_FAULT;
    end else if (last_mode_q != MODE_IDLE && last_mode_q != mode) begin
      // auto<->manual swap: stop this cycle, restart the sequence
      state_d  = S_THETA;
      settle_d = '0;
      drive_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_THETA;
          settle_d = '0;
          drive_d  = '0;
        end
        S_THETA: begin
          if (drive_q >= TIMEOUT_N) begin
            state_d = S_FAULT;
          end else if (th_bal) begin
            state_d  = S_THETA_SETTLE;
            settle_d = '0;
          end else begin
            th_d    = th_cmd;
            drive_d = drive_q + DW'(1);
          end
        end
        S_THETA_SETTLE: begin
          if (!th_bal) begin
            state_d = S_THETA;
            drive_d = '0;
          end else if (settle_nx == SETTLE_N) begin
            state_d  = S_PHI;
            settle_d = '0;
            drive_d  = '0;
          end else begin
            settle_d = settle_nx;
          end
        end
        S_PHI: begin
          if (drive_q >= TIMEOUT_N) begin
            state_d = S_FAULT;
          end else if (ph_bal) begin
            state_d  = S_PHI_SETTLE;
            settle_d = '0;
          end else begin
            ph_d    = ph_cmd;
            drive_d = drive_q + DW'(1);
          end
        end
        S_PHI_SETTLE: begin
          if (!ph_bal) begin
            state_d = S_PHI;
            drive_d = '0;
          end else if (settle_nx == SETTLE_N) begin
            state_d  = manual ? S_DONE : S_THETA;
            settle_d = '0;
            drive_d  = '0;
          end else begin
            settle_d = settle_nx;
          end
        end
        S_DONE: begin
          if (!th_bal || !ph_bal) begin
            state_d  = S_THETA;
            settle_d = '0;
            drive_d  = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d      = (state_d == S_THETA) || (state_d == S_THETA_SETTLE) ||
                  (state_d == S_PHI)   || (state_d == S_PHI_SETTLE);
    on_target_d = (state_d == S_DONE);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      drive_q     <= '0;
      last_mode_q <= MODE_IDLE;
      th_q        <= CMD_STOP;
      ph_q        <= CMD_STOP;
      busy_q      <= 1'b0;
      on_target_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      drive_q     <= drive_d;
      last_mode_q <= last_mode_d;
      th_q        <= th_d;
      ph_q        <= ph_d;
      busy_q      <= busy_d;
      on_target_q <= on_target_d;
      fault_q     <= fault_d;
    end
  end

  assign s_out_theta = th_q;
  assign s_out_phi   = ph_q;
  assign busy        = busy_q;
  assign on_target   = on_target_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_control_seguimiento.sv
// Directed bench for control_seguimiento: auto, manual wrap, settle,
// hold resume, timeout fault, reset mid-move and mode swap.
module tb_control_seguimiento;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] r_v1, r_v2, r_h1, r_h2;
  logic [15:0] theta_target, phi_target, theta_actual, phi_actual;
  logic [1:0]  s_out_theta, s_out_phi;
  logic        busy, on_target, fault;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_seguimiento #(
    .W(16), .DEADBAND(5), .ANGLE_MAX(360), .SETTLE(4), .TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .r_v1         (r_v1),
    .r_v2         (r_v2),
    .r_h1         (r_h1),
    .r_h2         (r_h2),
    .theta_target (theta_target),
    .phi_target   (phi_target),
    .theta_actual (theta_actual),
    .phi_actual   (phi_actual),
    .s_out_theta  (s_out_theta),
    .s_out_phi    (s_out_phi),
    .busy         (busy),
    .on_target    (on_target),
    .fault        (fault)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] got,
                     input logic [1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_th"},   s_out_theta, 2'b00);
    chk({tag, "_ph"},   s_out_phi,   2'b00);
    chk({tag, "_busy"}, {1'b0, busy},      2'b00);
    chk({tag, "_ont"},  {1'b0, on_target}, 2'b00);
    chk({tag, "_flt"},  {1'b0, fault},     2'b00);
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00;
    r_v1 = '0; r_v2 = '0; r_h1 = '0; r_h2 = '0;
    theta_target = '0; phi_target = '0;
    theta_actual = '0; phi_actual = '0;
    step(2);
    chk_all_zero("reset");
    rst = 1'b0;
    step(1);

    // automatic tracking
    r_v1 = 100; r_v2 = 50; r_h1 = 200; r_h2 = 200;
    mode = 2'b01;
    step(1);
    chk("auto_enter_busy", {1'b0, busy}, 2'b01);
    chk("auto_enter_th", s_out_theta, 2'b00);
    step(1);
    chk("auto_cw", s_out_theta, 2'b01);
    r_v1 = 3;
    step(1);
    chk("auto_no_underflow", s_out_theta, 2'b11);
    r_v1 = 52; r_h1 = 100; r_h2 = 200;
    step(1);
    chk("auto_balanced_stop", s_out_theta, 2'b00);
    step(3);
    chk("auto_settle_ph", s_out_phi, 2'b00);
    step(1);
    chk("auto_phi_entry_ph", s_out_phi, 2'b00);
    chk("auto_phi_entry_th", s_out_theta, 2'b00);
    chk("auto_phi_busy", {1'b0, busy}, 2'b01);
    step(1);
    chk("auto_phi_drive", s_out_phi, 2'b11);
    chk("auto_phi_th_stop", s_out_theta, 2'b00);

    // reset mid-move
    rst = 1'b1;
    step(1);
    chk_all_zero("rst_mid");
    mode = 2'b00; rst = 1'b0;
    step(1);

    // manual with wrap-around
    theta_actual = 350; theta_target = 10;
    phi_actual = 0; phi_target = 0;
    mode = 2'b10;
    step(2);
    chk("man_wrap_cw", s_out_theta, 2'b01);
    theta_target = 340;
    step(1);
    chk("man_ccw", s_out_theta, 2'b11);
    theta_target = 350; phi_target = 100;
    step(1);
    chk("man_bal_stop", s_out_theta, 2'b00);
    step(2);

    // hold during settle, then resume
    mode = 2'b11;
    step(2);
    chk("hold_th", s_out_theta, 2'b00);
    chk("hold_ph", s_out_phi, 2'b00);
    chk("hold_busy", {1'b0, busy}, 2'b01);
    mode = 2'b10;
    step(2);
    chk("resume_phi_entry", s_out_phi, 2'b00);
    step(1);
    chk("resume_phi_drive", s_out_phi, 2'b01);

    // converge to DONE
    phi_actual = 100;
    step(5);
    chk("done_ont", {1'b0, on_target}, 2'b01);
    chk("done_busy", {1'b0, busy}, 2'b00);
    chk("done_ph", s_out_phi, 2'b00);
    theta_actual = 300;
    step(1);
    chk("redo_ont", {1'b0, on_target}, 2'b00);
    chk("redo_busy", {1'b0, busy}, 2'b01);
    step(1);
    chk("redo_drive", s_out_theta, 2'b01);

    // timeout after 16 drive cycles
    step(15);
    chk("to_last_drive", s_out_theta, 2'b01);
    chk("to_not_yet", {1'b0, fault}, 2'b00);
    step(1);
    chk("to_fault", {1'b0, fault}, 2'b01);
    chk("to_th_stop", s_out_theta, 2'b00);
    chk("to_busy", {1'b0, busy}, 2'b00);
    mode = 2'b00;
    step(1);
    chk("to_clear", {1'b0, fault}, 2'b00);

    // auto -> manual swap stops motors and restarts
    r_v1 = 100; r_v2 = 50;
    mode = 2'b01;
    step(2);
    chk("swap_auto_drive", s_out_theta, 2'b01);
    mode = 2'b10;
    step(1);
    chk("swap_stop", s_out_theta, 2'b00);
    step(1);
    chk("swap_man_drive", s_out_theta, 2'b01);

    // invalid angle in manual
    theta_target = 400;
    step(1);
    chk("bad_angle_fault", {1'b0, fault}, 2'b01);
    chk("bad_angle_th", s_out_theta, 2'b00);
    mode = 2'b00;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_seguimiento.md
CONTROL_SEGUIMIENTO -- requirements
Module: control_seguimiento

Interface
REQ-001 SHALL have parameter W, default 16, sensor/angle width in bits.
REQ-002 SHALL have parameter DEADBAND, default 5, balance tolerance, inclusive.
REQ-003 SHALL have parameter ANGLE_MAX, default 360, angle modulus; valid angles are 0..ANGLE_MAX-1.
REQ-004 SHALL have parameter SETTLE, default 4, consecutive balanced cycles required before an axis is accepted.
REQ-005 SHALL have parameter TIMEOUT, default 1000000, maximum drive cycles per axis move.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset; one clock, reset synchronous and active-high.
REQ-007 SHALL have ports: mode in 2 (00 idle, 01 automatic, 10 manual, 11 hold); r_v1, r_v2, r_h1, r_h2 in W photoresistor readings.
REQ-008 SHALL have ports: theta_target, phi_target, theta_actual, phi_actual in W angles.
REQ-009 SHALL have ports: s_out_theta, s_out_phi out 2 motor commands; busy, on_target, fault out 1.

Function
REQ-010 SHALL encode motor commands as 00 stop, 01 clockwise/increasing, 11 counter-clockwise/decreasing; 10 is never driven.
REQ-011 SHALL register all outputs, one cycle from input sample to output.
REQ-012 SHALL implement the states IDLE, THETA, THETA_SETTLE, PHI, PHI_SETTLE, DONE and FAULT.
REQ-013 SHALL drive at most one axis at a time; s_out_phi=00 outside PHI, s_out_theta=00 outside THETA.
REQ-014 SHALL compute auto differences at W+1 bits with no unsigned underflow; balanced when |a-b|<=DEADBAND; otherwise a>b gives 01, a<b gives 11.
REQ-015 SHALL compute manual error as e=(target-actual) mod ANGLE_MAX; balanced when min(e, ANGLE_MAX-e)<=DEADBAND; else e<=ANGLE_MAX/2 gives 01 (tie gives 01), otherwise 11.
REQ-016 SHALL use r_v1/r_v2 for theta and r_h1/r_h2 for phi in mode 01, and target/actual pairs in mode 10.
REQ-017 SHALL go from IDLE to THETA when mode is 01 or 10.
REQ-018 SHALL go from THETA, when balanced, to THETA_SETTLE with a cleared settle counter.
REQ-019 SHALL count balanced cycles in THETA_SETTLE, return to THETA on any unbalanced cycle, and go to PHI after SETTLE balanced cycles; PHI/PHI_SETTLE behave likewise.
REQ-020 SHALL leave PHI_SETTLE to THETA in mode 01 (continuous tracking) or to DONE in mode 10.
REQ-021 SHALL keep outputs at 00 with on_target=1 in DONE, and go to THETA when either manual axis becomes unbalanced.
REQ-022 SHALL hold a per-move drive counter that clears on entry to THETA or PHI and increments each cycle with a non-zero command; on reaching TIMEOUT, go to FAULT.
REQ-023 SHALL go to FAULT in mode 10 when any target or actual is >=ANGLE_MAX.
REQ-024 SHALL drive all outputs 00 with fault=1 in FAULT, and leave FAULT only to IDLE on rst or mode=00.
REQ-025 SHALL, on a mode change between 01 and 10, stop both motors that cycle and restart at THETA with counters cleared.
REQ-026 SHALL freeze state and counters with outputs 00 in mode 11, and resume the frozen state when 11 is left to the prior mode.
REQ-027 SHALL go to IDLE on mode 00 from any state.
REQ-028 SHALL assert busy in THETA, THETA_SETTLE, PHI and PHI_SETTLE.

Reset
REQ-029 SHALL on rst enter IDLE, clear all counters and drive s_out_theta=00, s_out_phi=00, busy=0, on_target=0, fault=0 the next cycle, including mid-move.

Structure
REQ-030 SHALL place the motor command codes, mode codes and state enumeration in shared package seguimiento_pkg.
REQ-031 SHALL instantiate sub-module axis_cmp twice (theta, phi), combinationally producing balanced and direction for auto and manual inputs.

Verification
REQ-032 SHALL cover: mode 01, r_v1=100, r_v2=50 -> s_out_theta=01; then r_v1=52 held 4 cycles -> PHI entered, s_out_theta=00.
REQ-033 SHALL cover: mode 10, theta_actual=350, theta_target=10 -> s_out_theta=01 (wrap, 20 deg); target=340 -> 11.
REQ-034 SHALL cover: r_v1=3, r_v2=100 -> 11, with no underflow false-balance.
REQ-035 SHALL cover: mode 10, axes never converge, TIMEOUT=16 -> fault=1 after 16 drive cycles, outputs 00; mode=00 clears fault.
REQ-036 SHALL cover: rst asserted during PHI with s_out_phi=11 -> all outputs 00, IDLE next cycle.
REQ-037 SHALL cover: mode 11 entered in THETA_SETTLE after 2 balanced cycles, then back to 10 -> 2 more balanced cycles reach PHI.
